mem_read_align_buffer: RTL and testbench

MEM_READ_ALIGN_BUFFER -- requirements
Module: mem_read_align_buffer

---
 rtl/mem_read_pkg.sv | 13 +
 rtl/mem_read_align.sv | 55 +++++
 rtl/mem_read_align_buffer.sv | 87 ++++++++
 tb/tb_mem_read_align_buffer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_pkg.sv
// Shared encodings for the memory read alignment buffer.
package mem_read_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_W = 2'b01,
    SIZE_D = 2'b10,
    SIZE_Q = 2'b11
  } size_e;

  localparam int DEPTH_DEFAULT = 2;

endpackage

// File: rtl/mem_read_align.sv
// Shifts a raw 8-byte line down to the operand offset, masks it to the operand
// size and extends it; sign extension exists only when MEM_READ_SIGN_EXT_EN is defined.
module mem_read_align
  import mem_read_pkg::*;
(
  input  logic [63:0] data_i,
  input  logic [2:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  output logic [63:0] operand_o
);

  logic [63:0] shifted;
  logic [63:0] mask;
  logic [63:0] zext;

  // Zero fill from the shift makes bytes past the end of the line read as zero.
  assign shifted = data_i >> {addr_lo_i, 3'b000};

  always_comb begin
    mask = 64'h0;
    case (size_e'(size_i))
      SIZE_B:  mask = 64'h0000_0000_0000_00FF;
      SIZE_W:  mask = 64'h0000_0000_0000_FFFF;
      SIZE_D:  mask = 64'h0000_0000_FFFF_FFFF;
      SIZE_Q:  mask = 64'hFFFF_FFFF_FFFF_FFFF;
      default: mask = 64'h0;
    endcase
  end

  assign zext = shifted & mask;

`ifdef MEM_READ_SIGN_EXT_EN
  logic sign_bit;

  always_comb begin
    sign_bit = 1'b0;
    case (size_e'(size_i))
      SIZE_B:  sign_bit = shifted[7];
      SIZE_W:  sign_bit = shifted[15];
      SIZE_D:  sign_bit = shifted[31];
      SIZE_Q:  sign_bit = shifted[63];
      default: sign_bit = 1'b0;
    endcase
  end

  assign operand_o = (sext_i && sign_bit) ? (zext | ~mask) : zext;
`else
  logic unused_sext;

  assign unused_sext = sext_i;
  assign operand_o   = zext;
`endif

endmodule

// File: rtl/mem_read_align_buffer.sv
// Small FIFO of pre-aligned read operands between the DCache and execute.
// Optional sign extension is enabled with MEM_READ_SIGN_EXT_EN (see mem_read_align).
module mem_read_align_buffer
  import mem_read_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [2:0]  in_addr_lo,
  input  logic [1:0]  in_size,
  input  logic        in_sext,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [2:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
  localparam logic [2:0]       FULL_COUNT = 3'(DEPTH);

  logic [63:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  logic [63:0]      aligned;
  logic             enq;
  logic             deq;

  mem_read_align u_align (
    .data_i    (in_data),
    .addr_lo_i (in_addr_lo),
    .size_i    (in_size),
    .sext_i    (in_sext),
    .operand_o (aligned)
  );

  // Ready depends only on stored occupancy, so a full buffer never passes through.
  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != 3'd0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : 64'h0;
  assign count     = count_q;

  assign enq = in_valid && in_ready;
  assign deq = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (deq) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (enq && reset) begin
      mem_q[wr_ptr_q] <= aligned;
    end
  end

endmodule

// File: tb/tb_mem_read_align_buffer.sv
// Scoreboard bench for mem_read_align_buffer; expected operands come from a
// byte-level reference model, and MEM_READ_SIGN_EXT_EN selects the extension rule.
module tb_mem_read_align_buffer;

  localparam int DEPTH = 2;

`ifdef MEM_READ_SIGN_EXT_EN
  localparam logic [63:0] EXP_SEXT_CASE = 64'hFFFF_FFFF_F000_0000;
`else
  localparam logic [63:0] EXP_SEXT_CASE = 64'h0000_0000_F000_0000;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [2:0]  in_addr_lo;
  logic [1:0]  in_size;
  logic        in_sext;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [2:0]  count;

  logic [63:0] exp_q[$];
  bit          mon_en;
  int          n_checks;
  int          n_errors;

  mem_read_align_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_addr_lo (in_addr_lo),
    .in_size    (in_size),
    .in_sext    (in_sext),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Operand built byte by byte from the line, then optionally sign-filled.
  function automatic logic [63:0] refModel(input logic [63:0] d, input logic [2:0] a,
                                           input logic [1:0] s, input logic x);
    int          nb;
    logic [63:0] r;
    bit          do_ext;
    nb     = 1 << s;
    r      = '0;
    do_ext = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (int'(a) + i < 8) r[8*i +: 8] = d[8*(int'(a) + i) +: 8];
    end
`ifdef MEM_READ_SIGN_EXT_EN
    do_ext = x;
`endif
    if (do_ext && r[8*nb-1]) begin
      for (int i = nb; i < 8; i++) r[8*i +: 8] = 8'hFF;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks the presented head against the scoreboard, pops on dequeue.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("count", 64'(count), 64'(exp_q.size()));
      checkOutput("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
      checkOutput("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        checkOutput("out_data", out_data, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end else begin
        checkOutput("out_data_idle", out_data, 64'h0);
      end
    end
  end

  // One cycle of stimulus, driven 1 time unit after a rising edge; the
  // scoreboard is updated after the edge that completed the handshake.
  task automatic applyStimulus(input bit v, input logic [63:0] d, input logic [2:0] a,
                               input logic [1:0] s, input bit x, input bit ordy,
                               input bit rst_n, input bit use_exp, input logic [63:0] exp,
                               output bit accepted);
    bit rdy;
    in_valid   = v;
    in_data    = d;
    in_addr_lo = a;
    in_size    = s;
    in_sext    = x;
    out_ready  = ordy;
    reset      = rst_n;
    @(negedge clk);
    rdy = in_ready;
    @(posedge clk);
    #1;
    accepted = v && rdy && rst_n;
    if (!rst_n) exp_q.delete();
    else if (accepted) exp_q.push_back(use_exp ? exp : refModel(d, a, s, x));
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    applyStimulus(1'b0, 64'h0, 3'd0, 2'd0, 1'b0, ordy, 1'b1, 1'b0, 64'h0, acc);
  endtask

  task automatic sendBeat(input logic [63:0] d, input logic [2:0] a, input logic [1:0] s,
                          input bit x, input bit ordy, input bit use_exp, input logic [63:0] exp);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 16 && !acc; k++) begin
      applyStimulus(1'b1, d, a, s, x, ordy, 1'b1, use_exp, exp, acc);
    end
    if (!acc) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL enq_timeout: got no accept, expected accept within 16 cycles");
    end
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2; k++) idle(1'b1);
  endtask

  initial begin
    bit acc;
    n_checks   = 0;
    n_errors   = 0;
    mon_en     = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_addr_lo = '0;
    in_size    = '0;
    in_sext    = 1'b0;
    out_ready  = 1'b0;
    reset      = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 64'h0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, acc);
    mon_en = 1'b1;
    idle(1'b0);

    // Offset 3 halfword, then a negative word that depends on the extension build.
    sendBeat(64'h8877_6655_4433_2211, 3'd3, 2'b01, 1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_5544);
    idle(1'b1);
    sendBeat(64'h0000_0000_F000_0000, 3'd0, 2'b10, 1'b1, 1'b1, 1'b1, EXP_SEXT_CASE);
    drain();

    // Fill, offer one more while full, then drain in order.
    for (int k = 0; k < DEPTH; k++) sendBeat(64'hA0A0_0000_0000_0000 + 64'(k), 3'(k), 2'b11, 1'b0, 1'b0, 1'b0, 64'h0);
    applyStimulus(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 3'd0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, acc);
    checkOutput("full_reject", 64'(acc), 64'h0);
    drain();

    // Full with both handshakes offered: only the dequeue happens.
    for (int k = 0; k < DEPTH; k++) sendBeat(64'h1111_2222_3333_4444 + 64'(k), 3'd0, 2'b11, 1'b0, 1'b0, 1'b0, 64'h0);
    applyStimulus(1'b1, 64'h5555_6666_7777_8888, 3'd1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, acc);
    checkOutput("full_passthru", 64'(acc), 64'h0);
    applyStimulus(1'b1, 64'h5555_6666_7777_8888, 3'd1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0, acc);
    checkOutput("enq_after_deq", 64'(acc), 64'h1);
    drain();

    // Occupancy held at one across pointer wrap.
    sendBeat(64'h100, 3'd0, 2'b11, 1'b0, 1'b0, 1'b0, 64'h0);
    for (int k = 1; k <= 10; k++) sendBeat(64'h100 + 64'(k), 3'd0, 2'b11, 1'b0, 1'b1, 1'b0, 64'h0);
    drain();

    // Reset with two entries buffered and a handshake offered in the same cycle.
    sendBeat(64'hCAFE_0000_0000_0001, 3'd0, 2'b11, 1'b0, 1'b0, 1'b0, 64'h0);
    sendBeat(64'hCAFE_0000_0000_0002, 3'd0, 2'b11, 1'b0, 1'b0, 1'b0, 64'h0);
    applyStimulus(1'b1, 64'hCAFE_0000_0000_0003, 3'd0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, acc);
    idle(1'b0);
    sendBeat(64'hCAFE_0000_0000_0004, 3'd2, 2'b00, 1'b1, 1'b0, 1'b0, 64'h0);
    drain();

    // Randomized traffic with occasional reset.
    for (int k = 0; k < 600; k++) begin
      applyStimulus(bit'($urandom_range(0, 1)), {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                    bit'($urandom_range(0, 2) != 0), ($urandom_range(0, 49) != 0),
                    1'b0, 64'h0, acc);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule
